// File: rtl/in_dev_port.sv
// in_dev_port: FIFO-buffered device byte source presented to the processor input port over a 4-phase hs/ack handshake.
// Optional ack timeout enabled by defining IN_PORT_TIMEOUT_EN.
module in_dev_port #(
    parameter int DATA_W         = 8,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       g_clk,
    input  logic                       g_clr,
    input  logic                       src_valid,
    input  logic [DATA_W-1:0]          src_data,
    output logic                       src_ready,
    output logic [DATA_W-1:0]          input_bus,
    output logic                       in_dev_hs,
    input  logic                       in_dev_ack,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    output logic                       timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, PRESENT, RELEASE} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              full, push, pop, tmo;

    assign full       = count == CW'(DEPTH);
    assign src_ready  = !full;
    assign push       = src_valid && !full;
    assign pop        = state == PRESENT && in_dev_ack;
    assign in_dev_hs  = state == PRESENT;
    assign fifo_count = count;

`ifdef IN_PORT_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // Ack wins over a timeout landing on the same edge.
    assign tmo = state == PRESENT && !in_dev_ack && tmo_cnt == 16'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge g_clk) begin
        if (g_clr || state != PRESENT)
            tmo_cnt <= '0;
        else if (!in_dev_ack)
            tmo_cnt <= tmo_cnt + 16'd1;
        if (g_clr)
            timeout_err <= 1'b0;
        else if (tmo)
            timeout_err <= 1'b1;
    end
`else
    assign tmo         = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nx = (state == IDLE && count != '0)        ? PRESENT :
                   (state == PRESENT && (pop || tmo))    ? RELEASE :
                   (state == RELEASE && !in_dev_ack)     ? IDLE    : state;
    end

    always_ff @(posedge g_clk) begin
        if (push)
            mem[wr_ptr] <= src_data;
    end

    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            input_bus <= '0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nx;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (src_valid && full)
                overflow <= 1'b1;
            if (state == IDLE && count != '0)
                input_bus <= mem[rd_ptr];
        end
    end
endmodule

// File: tb/tb_in_dev_port.sv
// tb_in_dev_port: table-driven cycle vectors plus hand sequences for ordering/wrap and the optional ack timeout.
module tb_in_dev_port;
    logic       g_clk = 1'b0;
    logic       g_clr, src_valid, in_dev_ack;
    logic [7:0] src_data;
    logic       src_ready, in_dev_hs, overflow, timeout_err;
    logic [7:0] input_bus;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;

    in_dev_port #(.DATA_W(8), .DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
        .g_clk(g_clk), .g_clr(g_clr), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .input_bus(input_bus), .in_dev_hs(in_dev_hs),
        .in_dev_ack(in_dev_ack), .fifo_count(fifo_count), .overflow(overflow),
        .timeout_err(timeout_err)
    );

    always #5 g_clk = ~g_clk;

    typedef struct {
        logic       clr, v;
        logic [7:0] d;
        logic       ack, hs;
        logic [7:0] bus;
        logic [2:0] cnt;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic clr, v, input logic [7:0] d, input logic ack, hs,
                       input logic [7:0] bus, input logic [2:0] cnt, input logic ovf);
        vec_t r;
        r = '{clr: clr, v: v, d: d, ack: ack, hs: hs, bus: bus, cnt: cnt, ovf: ovf};
        vecs.push_back(r);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        src_valid = 1'b1;
        src_data  = d;
        tick();
        src_valid = 1'b0;
    endtask

    task automatic wait_hs();
        for (int k = 0; k < 20; k++) begin
            if (in_dev_hs) break;
            tick();
        end
    endtask

    logic [7:0] ord [6];

    initial begin
        g_clr = 1'b1; src_valid = 1'b0; src_data = 8'h00; in_dev_ack = 1'b0;
        //  clr v  d      ack hs bus    cnt ovf
        add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        add(0, 1, 8'h0A, 0, 0, 8'h00, 1, 0);
        add(0, 0, 8'h00, 0, 1, 8'h0A, 1, 0);
        add(0, 0, 8'h00, 1, 0, 8'h0A, 0, 0);
        add(0, 0, 8'h00, 1, 0, 8'h0A, 0, 0);
        add(0, 0, 8'h00, 0, 0, 8'h0A, 0, 0);
        add(0, 1, 8'hA1, 0, 0, 8'h0A, 1, 0);
        add(0, 1, 8'hA2, 0, 1, 8'hA1, 2, 0);
        add(0, 1, 8'hA3, 0, 1, 8'hA1, 3, 0);
        add(0, 1, 8'hA4, 0, 1, 8'hA1, 4, 0);
        add(0, 1, 8'hA5, 0, 1, 8'hA1, 4, 1);
        add(0, 0, 8'h00, 1, 0, 8'hA1, 3, 1);
        add(0, 0, 8'h00, 0, 0, 8'hA1, 3, 1);
        add(0, 0, 8'h00, 0, 1, 8'hA2, 3, 1);
        add(0, 0, 8'h00, 1, 0, 8'hA2, 2, 1);
        add(0, 0, 8'h00, 0, 0, 8'hA2, 2, 1);
        add(0, 0, 8'h00, 0, 1, 8'hA3, 2, 1);
        add(0, 1, 8'h77, 1, 0, 8'hA3, 2, 1);
        add(0, 0, 8'h00, 0, 0, 8'hA3, 2, 1);
        add(0, 0, 8'h00, 0, 1, 8'hA4, 2, 1);
        add(0, 0, 8'h00, 1, 0, 8'hA4, 1, 1);
        add(0, 0, 8'h00, 0, 0, 8'hA4, 1, 1);
        add(0, 0, 8'h00, 0, 1, 8'h77, 1, 1);
        add(0, 0, 8'h00, 1, 0, 8'h77, 0, 1);
        add(0, 0, 8'h00, 0, 0, 8'h77, 0, 1);
        add(0, 0, 8'h00, 1, 0, 8'h77, 0, 1);
        add(0, 1, 8'h33, 1, 0, 8'h77, 1, 1);
        add(0, 0, 8'h00, 1, 1, 8'h33, 1, 1);
        add(0, 0, 8'h00, 1, 0, 8'h33, 0, 1);
        add(0, 0, 8'h00, 0, 0, 8'h33, 0, 1);
        add(0, 1, 8'h01, 0, 0, 8'h33, 1, 1);
        add(0, 1, 8'h02, 0, 1, 8'h01, 2, 1);
        add(0, 1, 8'h03, 0, 1, 8'h01, 3, 1);
        add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        add(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);

        foreach (vecs[i]) begin
            g_clr      = vecs[i].clr;
            src_valid  = vecs[i].v;
            src_data   = vecs[i].d;
            in_dev_ack = vecs[i].ack;
            tick();
            check($sformatf("row%0d hs", i), 32'(in_dev_hs), 32'(vecs[i].hs));
            check($sformatf("row%0d bus", i), 32'(input_bus), 32'(vecs[i].bus));
            check($sformatf("row%0d cnt", i), 32'(fifo_count), 32'(vecs[i].cnt));
            check($sformatf("row%0d rdy", i), 32'(src_ready), 32'(vecs[i].cnt != 3'd4));
            check($sformatf("row%0d ovf", i), 32'(overflow), 32'(vecs[i].ovf));
            check($sformatf("row%0d tmo", i), 32'(timeout_err), 32'd0);
        end
        g_clr = 1'b0; src_valid = 1'b0; in_dev_ack = 1'b0;

        // Ordering across pointer wrap: three queued, refill one per delivered byte.
        ord = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 3; i++) push(ord[i]);
        for (int i = 0; i < 6; i++) begin
            wait_hs();
            check($sformatf("ord%0d hs", i), 32'(in_dev_hs), 32'd1);
            check($sformatf("ord%0d bus", i), 32'(input_bus), 32'(ord[i]));
            in_dev_ack = 1'b1;
            if (i + 3 < 6) push(ord[i+3]);
            else tick();
            check($sformatf("ord%0d hs_drop", i), 32'(in_dev_hs), 32'd0);
            in_dev_ack = 1'b0;
            tick();
        end
        check("ord final cnt", 32'(fifo_count), 32'd0);
        check("ord ovf", 32'(overflow), 32'd0);

`ifdef IN_PORT_TIMEOUT_EN
        g_clr = 1'b1;
        tick();
        g_clr = 1'b0;
        push(8'h5C);
        tick();
        check("tmo present", 32'(in_dev_hs), 32'd1);
        for (int k = 0; k < 7; k++) tick();
        check("tmo hs before", 32'(in_dev_hs), 32'd1);
        check("tmo err before", 32'(timeout_err), 32'd0);
        tick();
        check("tmo hs", 32'(in_dev_hs), 32'd0);
        check("tmo err", 32'(timeout_err), 32'd1);
        check("tmo cnt", 32'(fifo_count), 32'd1);
        tick();
        tick();
        check("tmo re hs", 32'(in_dev_hs), 32'd1);
        check("tmo re bus", 32'(input_bus), 32'h5C);
        in_dev_ack = 1'b1;
        tick();
        check("tmo pop cnt", 32'(fifo_count), 32'd0);
        in_dev_ack = 1'b0;
        tick();
        check("tmo sticky", 32'(timeout_err), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
